// File: rtl/data_mem_resp_if.sv
// Load/store request and response bundle between execute stage and data memory.
// The master drives the request side; the slave answers with the response.
interface data_mem_resp_if;
    logic        d_r_en;
    logic        d_w_en;
    logic [31:0] d_add;
    logic [31:0] d_wdata;
    logic [2:0]  f3;
    logic [4:0]  rd_in;
    logic        d_busy;
    logic        d_valid;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        ld_w_en;
    logic [4:0]  ld_rd;

    modport master (
        output d_r_en, d_w_en, d_add, d_wdata, f3, rd_in,
        input  d_busy, d_valid, d_err, d_rdata, ld_w_en, ld_rd
    );

    modport slave (
        input  d_r_en, d_w_en, d_add, d_wdata, f3, rd_in,
        output d_busy, d_valid, d_err, d_rdata, ld_w_en, ld_rd
    );
endinterface

// File: rtl/data_mem_resp.sv
// Word-organised data RAM with wait states, byte/half/word lane steering,
// load extension and alignment/range checking; one response pulse per request.
module data_mem_resp #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    data_mem_resp_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW+1:0] add_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;
    logic [4:0]    rd_q;
    logic          ok_q, ld_q, st_q;

    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ldw_q, ldw_d;
    logic [4:0]    ldrd_q, ldrd_d;

    logic          is_idle, accept, legal, commit, go;
    logic [AW+1:0] cur_add;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_f3;
    logic [4:0]    cur_rd;
    logic          cur_ok, cur_ld, cur_st;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlane, word, shifted, ext;

    logic [31:0]   mem [DEPTH];

    assign is_idle = (state_q == IDLE);
    assign accept  = is_idle && (bus.d_r_en || bus.d_w_en);

    // Commit/read happen either straight from IDLE or after WAIT, so pick live or captured
    assign cur_add   = is_idle ? bus.d_add[AW+1:0] : add_q;
    assign cur_wdata = is_idle ? bus.d_wdata : wdata_q;
    assign cur_f3    = is_idle ? bus.f3 : f3_q;
    assign cur_rd    = is_idle ? bus.rd_in : rd_q;
    assign cur_ok    = is_idle ? legal : ok_q;
    assign cur_ld    = is_idle ? (bus.d_r_en && !bus.d_w_en) : ld_q;
    assign cur_st    = is_idle ? (bus.d_w_en && !bus.d_r_en) : st_q;
    assign idx       = cur_add[AW+1:2];

    always_comb begin
        legal = 1'b0;
        unique case (bus.f3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = !bus.d_add[0];
            3'b010:         legal = (bus.d_add[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
        if (bus.d_w_en && bus.f3[2]) legal = 1'b0;
        if (bus.d_r_en && bus.d_w_en) legal = 1'b0;
        if (bus.d_add[31:2] >= 30'(DEPTH)) legal = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!legal || WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = legal;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        be    = 4'hF;
        wlane = cur_wdata;
        unique case (cur_f3[1:0])
            2'b00: begin
                be    = 4'b0001 << cur_add[1:0];
                wlane = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be    = cur_add[1] ? 4'b1100 : 4'b0011;
                wlane = {2{cur_wdata[15:0]}};
            end
            default: be = 4'hF;
        endcase
    end

    assign word    = mem[idx];
    assign shifted = word >> {cur_add[1:0], 3'b000};

    always_comb begin
        ext = word;
        unique case (cur_f3)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'b0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'b0, shifted[15:0]};
            default: ext = word;
        endcase
    end

    assign go      = (state_d == RESP) && (state_q != RESP);
    assign valid_d = go;
    assign err_d   = go && !cur_ok;
    assign ldw_d   = go && cur_ok && cur_ld;
    assign rdata_d = ldw_d ? ext : 32'b0;
    assign ldrd_d  = ldw_d ? cur_rd : 5'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            add_q   <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            ok_q    <= 1'b0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            ldw_q   <= 1'b0;
            ldrd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                add_q   <= bus.d_add[AW+1:0];
                wdata_q <= bus.d_wdata;
                f3_q    <= bus.f3;
                rd_q    <= bus.rd_in;
                ok_q    <= legal;
                ld_q    <= bus.d_r_en && !bus.d_w_en;
                st_q    <= bus.d_w_en && !bus.d_r_en;
            end
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ldw_q   <= ldw_d;
            ldrd_q  <= ldrd_d;
        end
    end

    // No reset on the array; the rst gate keeps an in-reset request from writing
    always_ff @(posedge clk) begin
        if (rst && commit && cur_st) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    assign bus.d_busy  = !is_idle;
    assign bus.d_valid = valid_q;
    assign bus.d_err   = err_q;
    assign bus.d_rdata = rdata_q;
    assign bus.ld_w_en = ldw_q;
    assign bus.ld_rd   = ldrd_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: byte-level memory model plus per-cycle output compare,
// one instance with two wait states and one with none.
module tb_data_mem_resp;

    localparam int DEPTH = 1024;

    typedef struct packed {
        logic        busy;
        logic        valid;
        logic        err;
        logic [31:0] rdata;
        logic        ldw;
        logic [4:0]  rd;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        r_en [2];
    logic        w_en [2];
    logic [31:0] add  [2];
    logic [31:0] wd   [2];
    logic [2:0]  f3   [2];
    logic [4:0]  rd   [2];

    data_mem_resp_if ifa ();
    data_mem_resp_if ifb ();

    assign ifa.d_r_en  = r_en[0];
    assign ifa.d_w_en  = w_en[0];
    assign ifa.d_add   = add[0];
    assign ifa.d_wdata = wd[0];
    assign ifa.f3      = f3[0];
    assign ifa.rd_in   = rd[0];
    assign ifb.d_r_en  = r_en[1];
    assign ifb.d_w_en  = w_en[1];
    assign ifb.d_add   = add[1];
    assign ifb.d_wdata = wd[1];
    assign ifb.f3      = f3[1];
    assign ifb.rd_in   = rd[1];

    data_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    data_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    obs_t        ex [int];
    logic [7:0]  mm [int];
    int          cyc = 0;
    int          lat_w [2] = '{2, 0};
    int          next_ok [2];
    int          last_lat [2];
    logic [31:0] last_rd [2];
    int          n_acc [2];
    logic        pend [2];
    int          pend_cyc [2];
    logic [31:0] pend_a [2];
    logic [31:0] pend_d [2];
    logic [2:0]  pend_f [2];
    int          nvec = 0;
    int          nmiss = 0;

    function automatic int ekey(int i, int c);
        return i * 1000000 + c;
    endfunction

    function automatic int mkey(int i, logic [31:0] a);
        return i * 65536 + int'(a[15:0]);
    endfunction

    function automatic logic is_legal(logic r, logic w, logic [31:0] a,
                                      logic [2:0] f);
        logic ok;
        if (r && w) return 1'b0;
        case (f)
            3'd0, 3'd4: ok = 1'b1;
            3'd1, 3'd5: ok = (a % 2 == 0);
            3'd2:       ok = (a % 4 == 0);
            default:    ok = 1'b0;
        endcase
        if (w && f > 3'd2) ok = 1'b0;
        if ((a / 4) >= DEPTH) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [31:0] model_load(int i, logic [31:0] a,
                                               logic [2:0] f);
        int n;
        longint unsigned v, t;
        n = 1 << f[1:0];
        v = 0;
        for (int b = 0; b < n; b++) begin
            t = mm.exists(mkey(i, a + b)) ? longint'(mm[mkey(i, a + b)]) : 0;
            v = v | (t << (8 * b));
        end
        if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
        return v[31:0];
    endfunction

    function automatic void model_store(int i, logic [31:0] a,
                                        logic [31:0] d, logic [2:0] f);
        int n;
        n = 1 << f[1:0];
        for (int b = 0; b < n; b++) mm[mkey(i, a + b)] = d[8*b +: 8];
    endfunction

    // Reference: a request occupies 2+latency cycles; the store lands on the response edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                pend[i]    = 1'b0;
                next_ok[i] = 0;
                for (int k = 0; k < 8; k++)
                    if (ex.exists(ekey(i, cyc + k))) ex.delete(ekey(i, cyc + k));
            end else begin
                if (pend[i] && pend_cyc[i] == cyc) begin
                    model_store(i, pend_a[i], pend_d[i], pend_f[i]);
                    pend[i] = 1'b0;
                end
                if ((r_en[i] || w_en[i]) && cyc >= next_ok[i]) begin
                    logic ok;
                    int   lat;
                    obs_t e;
                    ok  = is_legal(r_en[i], w_en[i], add[i], f3[i]);
                    lat = ok ? lat_w[i] : 0;
                    e   = '0;
                    e.busy = 1'b1;
                    for (int c = 0; c <= lat; c++) ex[ekey(i, cyc + c)] = e;
                    e.valid = 1'b1;
                    e.err   = !ok;
                    if (ok && r_en[i]) begin
                        e.rdata = model_load(i, add[i], f3[i]);
                        e.ldw   = 1'b1;
                        e.rd    = rd[i];
                    end
                    ex[ekey(i, cyc + lat)] = e;
                    if (ok && w_en[i]) begin
                        if (lat == 0) begin
                            model_store(i, add[i], wd[i], f3[i]);
                        end else begin
                            pend[i]     = 1'b1;
                            pend_cyc[i] = cyc + lat;
                            pend_a[i]   = add[i];
                            pend_d[i]   = wd[i];
                            pend_f[i]   = f3[i];
                        end
                    end
                    last_lat[i] = lat;
                    last_rd[i]  = e.rdata;
                    n_acc[i]    = n_acc[i] + 1;
                    next_ok[i]  = cyc + lat + 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            obs_t e, a;
            e = '0;
            if (rst && ex.exists(ekey(i, cyc))) e = ex[ekey(i, cyc)];
            if (i == 0)
                a = {ifa.d_busy, ifa.d_valid, ifa.d_err, ifa.d_rdata,
                     ifa.ld_w_en, ifa.ld_rd};
            else
                a = {ifb.d_busy, ifb.d_valid, ifb.d_err, ifb.d_rdata,
                     ifb.ld_w_en, ifb.ld_rd};
            nvec = nvec + 1;
            if (a !== e) begin
                nmiss = nmiss + 1;
                $display("FAIL cycle%0d dut%0d {busy,valid,err,rdata,ldw,rd} got=%h exp=%h",
                         cyc, i, a, e);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nvec = nvec + 1;
        if (got !== exp) begin
            nmiss = nmiss + 1;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic issue(int i, logic r, logic w, logic [31:0] a,
                         logic [31:0] d, logic [2:0] f, logic [4:0] rg);
        r_en[i] = r;
        w_en[i] = w;
        add[i]  = a;
        wd[i]   = d;
        f3[i]   = f;
        rd[i]   = rg;
        @(posedge clk);
        #1;
        r_en[i] = 1'b0;
        w_en[i] = 1'b0;
        repeat (last_lat[i] + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            r_en[i] = 0; w_en[i] = 0; add[i] = 0; wd[i] = 0;
            f3[i] = 0; rd[i] = 0; next_ok[i] = 0; last_lat[i] = 0;
            last_rd[i] = 0; n_acc[i] = 0; pend[i] = 0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 5'd0);
        chk("sw_lat", 32'(last_lat[0]), 32'd2);
        issue(0, 1, 0, 32'h10, 32'h0, 3'd2, 5'd5);
        chk("lw_data", last_rd[0], 32'hDEADBEEF);
        chk("lw_lat", 32'(last_lat[0]), 32'd2);

        issue(0, 0, 1, 32'h20, 32'h80F17F01, 3'd2, 5'd0);
        issue(0, 1, 0, 32'h23, 32'h0, 3'd0, 5'd1);
        chk("lb", last_rd[0], 32'hFFFFFF80);
        issue(0, 1, 0, 32'h23, 32'h0, 3'd4, 5'd2);
        chk("lbu", last_rd[0], 32'h00000080);
        issue(0, 1, 0, 32'h20, 32'h0, 3'd1, 5'd3);
        chk("lh", last_rd[0], 32'h00007F01);
        issue(0, 1, 0, 32'h22, 32'h0, 3'd5, 5'd4);
        chk("lhu", last_rd[0], 32'h000080F1);

        issue(0, 0, 1, 32'h40, 32'h11223344, 3'd2, 5'd0);
        issue(0, 0, 1, 32'h41, 32'hFFFFFFAA, 3'd0, 5'd0);
        issue(0, 0, 1, 32'h42, 32'h1234BEEF, 3'd1, 5'd0);
        issue(0, 1, 0, 32'h40, 32'h0, 3'd2, 5'd6);
        chk("merge", last_rd[0], 32'hBEEFAA44);

        issue(0, 1, 0, 32'h22, 32'h0, 3'd2, 5'd7);
        chk("mis_lw_lat", 32'(last_lat[0]), 32'd0);
        issue(0, 0, 1, 32'h21, 32'h0000FFFF, 3'd1, 5'd0);
        chk("mis_sh_lat", 32'(last_lat[0]), 32'd0);
        issue(0, 1, 0, 32'h20, 32'h0, 3'd3, 5'd8);
        chk("f3_011_lat", 32'(last_lat[0]), 32'd0);
        issue(0, 1, 0, DEPTH * 4, 32'h0, 3'd2, 5'd9);
        chk("range_lat", 32'(last_lat[0]), 32'd0);
        issue(0, 1, 1, 32'h20, 32'h0, 3'd2, 5'd10);
        chk("both_lat", 32'(last_lat[0]), 32'd0);
        issue(0, 1, 0, 32'h20, 32'h0, 3'd2, 5'd11);
        chk("unchanged", last_rd[0], 32'h80F17F01);

        issue(0, 0, 1, 32'h100, 32'h55667788, 3'd2, 5'd0);
        w_en[0] = 1'b1;
        add[0]  = 32'h100;
        wd[0]   = 32'h0BADF00D;
        f3[0]   = 3'd2;
        @(posedge clk);
        #1 w_en[0] = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_flags", {28'b0, ifa.d_busy, ifa.d_valid, ifa.d_err, ifa.ld_w_en},
            32'h0);
        chk("rst_rdata", ifa.d_rdata, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 1, 0, 32'h100, 32'h0, 3'd2, 5'd12);
        chk("abort_keep", last_rd[0], 32'h55667788);

        issue(1, 0, 1, 32'h8, 32'h12345678, 3'd2, 5'd0);
        chk("w0_lat", 32'(last_lat[1]), 32'd0);
        n_acc[1] = 0;
        r_en[1]  = 1'b1;
        add[1]   = 32'h8;
        f3[1]    = 3'd2;
        rd[1]    = 5'd7;
        repeat (10) @(posedge clk);
        #1 r_en[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stream_cnt", 32'(n_acc[1]), 32'd5);
        chk("stream_data", last_rd[1], 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder for the RV32 core; the memory-side end of the load/store request the execute stage issues (d_r_en, d_w_en, d_add, store data, f3).
- Owns a word-organised data RAM with configurable wait states.
- Performs byte/half/word lane steering, load sign/zero extension and alignment/range checking.
- Returns load data with a one-cycle valid pulse and the destination register for write-back.

Parameters:
DEPTH, 1024, number of 32-bit words in the RAM; index = d_add[31:2].
WAIT_CYCLES, 2, extra cycles between request acceptance and response (0 legal).

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-low reset
d_r_en  input  1  load request
d_w_en  input  1  store request
d_add  input  32  byte address
d_wdata  input  32  store data, right-justified
f3  input  3  RV32 funct3 width/sign code
rd_in  input  5  load destination register
d_busy  output  1  request in flight, new requests ignored
d_valid  output  1  one-cycle response pulse (loads and stores)
d_err  output  1  qualifies d_valid: misaligned, illegal f3 or out of range
d_rdata  output  32  extended load data, 0 for stores/errors
ld_w_en  output  1  register-file write strobe, = d_valid & load & !d_err
ld_rd  output  5  captured rd_in, valid with ld_w_en

Behaviour:
- Reset (rst=0, async): FSM to IDLE, wait counter 0, all outputs 0. RAM contents not reset. Reset mid-transaction aborts it: no response, and a store not yet committed is never written.
- Accept: posedge in IDLE with (d_r_en|d_w_en)=1 and d_busy=0. Capture d_add, d_wdata, f3, rd_in, type.
- Both enables high on accept: error request, no RAM access.
- Request inputs outside the accept edge are ignored (no queueing).
- Legality check at accept:
  - f3 000/100: any address.
  - f3 001/101: requires d_add[0]=0.
  - f3 010: requires d_add[1:0]=0.
  - Stores: only 000/001/010 legal.
  - f3 011/110/111: always illegal.
  - d_add[31:2] >= DEPTH: illegal.
- FSM IDLE -> WAIT -> RESP -> IDLE.
  - WAIT holds for WAIT_CYCLES cycles, counter counts down to 0.
  - WAIT_CYCLES=0 or an illegal request: IDLE -> RESP directly.
  - RESP lasts exactly one cycle; d_valid=1 during it.
- Latency: accept at edge N gives d_valid high in cycle N+1+WAIT_CYCLES, or N+1 on error.
- d_busy=1 in WAIT and RESP. Next accept is possible at the edge ending RESP, giving back-to-back throughput of one per 2+WAIT_CYCLES cycles.
- Store commit on the WAIT->RESP edge (IDLE->RESP edge when WAIT_CYCLES=0), legal only. Byte-lane mask:
  - sb: d_wdata[7:0] into lane d_add[1:0].
  - sh: d_wdata[15:0] into lanes {d_add[1],0}/{d_add[1],1}.
  - sw: all 4 lanes.
  - Untouched lanes keep their value.
- Load: word read on the same edge, lane selected by captured d_add[1:0].
  - f3 000 (lb) sign-extends bit 7; 100 (lbu) zero-extends.
  - f3 001 (lh) sign-extends bit 15; 101 (lhu) zero-extends.
  - f3 010 (lw) is unmodified.
- Read-after-write: a load accepted after a store's RESP returns the stored data.
- d_rdata, d_err, ld_w_en, ld_rd are registered and held 0 outside RESP.

Test Plan:
- WAIT_CYCLES=2: sw 0xDEADBEEF @0x10 then lw @0x10 with rd_in=5. Response: valid 3 cycles after each accept; load gives d_rdata=0xDEADBEEF, ld_w_en=1, ld_rd=5, d_err=0.
- Word 0x80F17F01 @0x20: lb @0x23 -> 0xFFFFFF80; lbu @0x23 -> 0x00000080; lh @0x20 -> 0x00007F01; lhu @0x22 -> 0x000080F1.
- Word 0x11223344 @0x40, then sb 0xAA @0x41 and sh 0xBEEF @0x42. lw @0x40 -> 0xBEEFAA44.
- lw @0x22, sh @0x21, f3=011, and d_add=DEPTH*4: each gives d_valid=d_err=1 one cycle after accept, d_rdata=0, ld_w_en=0; RAM unchanged.
- Hold d_r_en high for 10 cycles with WAIT_CYCLES=0: exactly one response per 2 cycles, d_busy pattern 1,0 alternating.
- Store accepted, rst pulsed low during WAIT: outputs 0 immediately; target word retains its old value; no d_valid.
